// File: rtl/pc_sequencer.sv
//------------------------------------------------------------------------------
// Module      : pc_sequencer
// Description : Fetch-stage PC sequencer. Steps PC by 4, holds it on a stall
//               and redirects to the EX branch target. Also drives pipeline
//               flushes and two saturating performance counters.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pc_sequencer #(
  parameter int              ADDR_W   = 8,
  parameter int              IMM_W    = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int              CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              ex_valid,
  input  logic              ex_branch,
  input  logic              ex_zero,
  input  logic [ADDR_W-1:0] ex_pc,
  input  logic [IMM_W-1:0]  ex_imm,
  input  logic              clr_cnt,
  output logic [ADDR_W-1:0] pc_out,
  output logic              fetch_valid,
  output logic              if_id_flush,
  output logic              id_ex_flush,
  output logic              redirect,
  output logic [CNT_W-1:0]  taken_cnt,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [1:0] S_BOOT  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;

  localparam logic [ADDR_W-1:0] c_PC_STEP = ADDR_W'(4);
  localparam logic [CNT_W-1:0]  c_CNT_MAX = '1;

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_nxt;
  logic [ADDR_W-1:0] w_target;
  logic              w_taken;
  logic              w_stall_evt;
  logic [CNT_W-1:0]  r_taken_cnt;
  logic [CNT_W-1:0]  r_stall_cnt;

  // Only RUN may redirect: FLUSH holds a squashed bubble in EX.
  assign w_taken     = (r_state == S_RUN) & ex_valid & ex_branch & ex_zero;
  assign w_target    = ex_pc + ex_imm[ADDR_W-1:0];
  assign w_stall_evt = (r_state != S_BOOT) & stall & ~w_taken;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_BOOT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_BOOT:  w_state_nxt = S_RUN;
      S_RUN:   w_state_nxt = w_taken ? S_FLUSH : S_RUN;
      S_FLUSH: w_state_nxt = S_RUN;
      default: w_state_nxt = S_BOOT;
    endcase
  end

  always_comb begin
    fetch_valid = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    redirect    = 1'b0;
    w_pc_nxt    = r_pc;
    case (r_state)
      S_RUN: begin
        fetch_valid = ~stall;
        if (w_taken) begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          redirect    = 1'b1;
          w_pc_nxt    = w_target;
        end else if (!stall) begin
          w_pc_nxt = r_pc + c_PC_STEP;
        end
      end
      S_FLUSH: begin
        fetch_valid = ~stall;
        if (!stall) begin
          w_pc_nxt = r_pc + c_PC_STEP;
        end
      end
      default: begin
        w_pc_nxt = r_pc;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= RESET_PC;
    end else begin
      r_pc <= w_pc_nxt;
    end
  end

  // Clear takes precedence over a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_taken_cnt <= '0;
      r_stall_cnt <= '0;
    end else if (clr_cnt) begin
      r_taken_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_taken && (r_taken_cnt != c_CNT_MAX)) begin
        r_taken_cnt <= r_taken_cnt + 1'b1;
      end
      if (w_stall_evt && (r_stall_cnt != c_CNT_MAX)) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
    end
  end

  assign pc_out    = r_pc;
  assign taken_cnt = r_taken_cnt;
  assign stall_cnt = r_stall_cnt;

endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
//------------------------------------------------------------------------------
// Module      : tb_pc_sequencer
// Description : Directed self-checking bench for pc_sequencer.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_pc_sequencer;

  localparam int ADDR_W = 8;
  localparam int IMM_W  = 64;
  localparam int CNT_W  = 4;

  logic              clk;
  logic              rst_n;
  logic              stall;
  logic              ex_valid;
  logic              ex_branch;
  logic              ex_zero;
  logic [ADDR_W-1:0] ex_pc;
  logic [IMM_W-1:0]  ex_imm;
  logic              clr_cnt;
  logic [ADDR_W-1:0] pc_out;
  logic              fetch_valid;
  logic              if_id_flush;
  logic              id_ex_flush;
  logic              redirect;
  logic [CNT_W-1:0]  taken_cnt;
  logic [CNT_W-1:0]  stall_cnt;

  int checks   = 0;
  int failures = 0;

  pc_sequencer #(
    .ADDR_W  (ADDR_W),
    .IMM_W   (IMM_W),
    .RESET_PC(8'h00),
    .CNT_W   (CNT_W)
  ) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .stall      (stall),
    .ex_valid   (ex_valid),
    .ex_branch  (ex_branch),
    .ex_zero    (ex_zero),
    .ex_pc      (ex_pc),
    .ex_imm     (ex_imm),
    .clr_cnt    (clr_cnt),
    .pc_out     (pc_out),
    .fetch_valid(fetch_valid),
    .if_id_flush(if_id_flush),
    .id_ex_flush(id_ex_flush),
    .redirect   (redirect),
    .taken_cnt  (taken_cnt),
    .stall_cnt  (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input logic v, input logic b, input logic z,
                        input logic [ADDR_W-1:0] pc, input logic [IMM_W-1:0] imm);
    ex_valid  = v;
    ex_branch = b;
    ex_zero   = z;
    ex_pc     = pc;
    ex_imm    = imm;
  endtask

  task automatic chk_flushes(input string tag, input logic exp);
    chk({tag, "_redirect"}, 64'(redirect), 64'(exp));
    chk({tag, "_if_id"},    64'(if_id_flush), 64'(exp));
    chk({tag, "_id_ex"},    64'(id_ex_flush), 64'(exp));
  endtask

  initial begin
    rst_n   = 1'b0;
    stall   = 1'b0;
    clr_cnt = 1'b0;
    set_ex(1'b0, 1'b0, 1'b0, 8'h00, 64'h0);
    #3;
    chk("rst_pc", 64'(pc_out), 64'h00);
    chk("rst_fv", 64'(fetch_valid), 64'h0);
    chk("rst_taken_cnt", 64'(taken_cnt), 64'h0);
    chk("rst_stall_cnt", 64'(stall_cnt), 64'h0);
    step();
    step();
    rst_n = 1'b1;
    #1;
    // BOOT cycle
    chk("boot_pc", 64'(pc_out), 64'h00);
    chk("boot_fv", 64'(fetch_valid), 64'h0);
    step();
    chk("run0_pc", 64'(pc_out), 64'h00);
    chk("run0_fv", 64'(fetch_valid), 64'h1);
    step();
    chk("run1_pc", 64'(pc_out), 64'h04);
    step();
    chk("run2_pc", 64'(pc_out), 64'h08);

    // Taken branch: 0x20 + 0x10
    set_ex(1'b1, 1'b1, 1'b1, 8'h20, 64'h10);
    #1;
    chk_flushes("br", 1'b1);
    step();
    chk("br_target", 64'(pc_out), 64'h30);
    chk("br_taken_cnt", 64'(taken_cnt), 64'h1);
    // EX still looks taken during FLUSH but must be ignored
    chk_flushes("flush_ign", 1'b0);
    chk("flush_fv", 64'(fetch_valid), 64'h1);
    step();
    set_ex(1'b0, 1'b0, 1'b0, 8'h00, 64'h0);
    chk("post_br_pc", 64'(pc_out), 64'h34);

    // Not-taken forms
    set_ex(1'b1, 1'b1, 1'b0, 8'h20, 64'h10);
    #1;
    chk_flushes("nt_zero0", 1'b0);
    step();
    chk("nt_zero0_pc", 64'(pc_out), 64'h38);
    set_ex(1'b0, 1'b1, 1'b1, 8'h20, 64'h10);
    #1;
    chk_flushes("nt_invalid", 1'b0);
    step();
    chk("nt_invalid_pc", 64'(pc_out), 64'h3C);
    chk("nt_taken_cnt", 64'(taken_cnt), 64'h1);
    set_ex(1'b0, 1'b0, 1'b0, 8'h00, 64'h0);

    // Three stall cycles
    stall = 1'b1;
    #1;
    chk("stall_fv", 64'(fetch_valid), 64'h0);
    for (int i = 0; i < 3; i++) step();
    stall = 1'b0;
    chk("stall_pc", 64'(pc_out), 64'h3C);
    chk("stall_cnt3", 64'(stall_cnt), 64'h3);

    // Stall together with taken, negative immediate: 0x20 - 8
    stall = 1'b1;
    set_ex(1'b1, 1'b1, 1'b1, 8'h20, 64'hFFFF_FFFF_FFFF_FFF8);
    #1;
    chk_flushes("st_br", 1'b1);
    step();
    stall = 1'b0;
    set_ex(1'b0, 1'b0, 1'b0, 8'h00, 64'h0);
    chk("st_br_pc", 64'(pc_out), 64'h18);
    chk("st_br_stall_cnt", 64'(stall_cnt), 64'h3);
    chk("st_br_taken_cnt", 64'(taken_cnt), 64'h2);
    step();
    chk("st_br_next_pc", 64'(pc_out), 64'h1C);

    // Target wrap: 0xF0 + 0x20
    set_ex(1'b1, 1'b1, 1'b1, 8'hF0, 64'h20);
    step();
    set_ex(1'b0, 1'b0, 1'b0, 8'h00, 64'h0);
    chk("wrap_target", 64'(pc_out), 64'h10);
    step();
    chk("wrap_target_next", 64'(pc_out), 64'h14);

    // PC+4 wrap out of FLUSH: redirect to 0xFC, then 0x00
    set_ex(1'b1, 1'b1, 1'b1, 8'hF0, 64'h0C);
    step();
    set_ex(1'b0, 1'b0, 1'b0, 8'h00, 64'h0);
    chk("pc_fc", 64'(pc_out), 64'hFC);
    step();
    chk("pc_wrap", 64'(pc_out), 64'h00);
    chk("taken_cnt4", 64'(taken_cnt), 64'h4);

    // Clear wins over same-cycle stall increment
    stall   = 1'b1;
    clr_cnt = 1'b1;
    step();
    stall   = 1'b0;
    clr_cnt = 1'b0;
    chk("clr_stall_cnt", 64'(stall_cnt), 64'h0);
    chk("clr_taken_cnt", 64'(taken_cnt), 64'h0);

    // Clear wins over same-cycle redirect increment
    set_ex(1'b1, 1'b1, 1'b1, 8'h40, 64'h0);
    clr_cnt = 1'b1;
    step();
    clr_cnt = 1'b0;
    set_ex(1'b0, 1'b0, 1'b0, 8'h00, 64'h0);
    chk("clr_br_pc", 64'(pc_out), 64'h40);
    chk("clr_br_taken_cnt", 64'(taken_cnt), 64'h0);

    // Stall in FLUSH holds PC and counts
    stall = 1'b1;
    #1;
    chk("flush_stall_fv", 64'(fetch_valid), 64'h0);
    step();
    stall = 1'b0;
    chk("flush_stall_pc", 64'(pc_out), 64'h40);
    chk("flush_stall_cnt", 64'(stall_cnt), 64'h1);
    step();
    chk("flush_stall_next", 64'(pc_out), 64'h44);

    // Saturation of stall counter
    stall = 1'b1;
    for (int i = 0; i < 20; i++) step();
    stall = 1'b0;
    chk("stall_sat", 64'(stall_cnt), 64'hF);
    chk("stall_sat_pc", 64'(pc_out), 64'h44);

    // Enter FLUSH, then reset asynchronously between edges
    set_ex(1'b1, 1'b1, 1'b1, 8'h80, 64'h0);
    step();
    chk("pre_rst_pc", 64'(pc_out), 64'h80);
    stall = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_pc", 64'(pc_out), 64'h00);
    chk("async_fv", 64'(fetch_valid), 64'h0);
    chk_flushes("async", 1'b0);
    chk("async_taken_cnt", 64'(taken_cnt), 64'h0);
    chk("async_stall_cnt", 64'(stall_cnt), 64'h0);

    step();
    rst_n = 1'b1;
    stall = 1'b0;
    set_ex(1'b0, 1'b0, 1'b0, 8'h00, 64'h0);
    step();
    step();
    chk("rerun_pc", 64'(pc_out), 64'h04);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
